// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory among dmem, imem and host requesters.
// One transaction in flight; fixed priority with host anti-starvation promotion.
module mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int HOST_MAX_WAIT = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,

  input  logic                                 imem_req_valid,
  output logic                                 imem_req_ready,
  input  logic [ADDR_W-1:0]                    imem_req_addr,
  input  logic                                 imem_req_wen,
  input  logic [DATA_W/8-1:0]                  imem_req_wstrb,
  input  logic [DATA_W-1:0]                    imem_req_wdata,
  output logic                                 imem_resp_valid,
  output logic [DATA_W-1:0]                    imem_resp_rdata,

  input  logic                                 dmem_req_valid,
  output logic                                 dmem_req_ready,
  input  logic [ADDR_W-1:0]                    dmem_req_addr,
  input  logic                                 dmem_req_wen,
  input  logic [DATA_W/8-1:0]                  dmem_req_wstrb,
  input  logic [DATA_W-1:0]                    dmem_req_wdata,
  output logic                                 dmem_resp_valid,
  output logic [DATA_W-1:0]                    dmem_resp_rdata,

  input  logic                                 host_req_valid,
  output logic                                 host_req_ready,
  input  logic [ADDR_W-1:0]                    host_req_addr,
  input  logic                                 host_req_wen,
  input  logic [DATA_W/8-1:0]                  host_req_wstrb,
  input  logic [DATA_W-1:0]                    host_req_wdata,
  output logic                                 host_resp_valid,
  output logic [DATA_W-1:0]                    host_resp_rdata,

  output logic                                 mem_req_valid,
  input  logic                                 mem_req_ready,
  output logic [ADDR_W-1:0]                    mem_req_addr,
  output logic                                 mem_req_wen,
  output logic [DATA_W/8-1:0]                  mem_req_wstrb,
  output logic [DATA_W-1:0]                    mem_req_wdata,
  input  logic                                 mem_resp_valid,
  input  logic [DATA_W-1:0]                    mem_resp_rdata,

  output logic                                 busy,
  output logic                                 spurious_resp,

  output logic                                 dbg_state,
  output logic [1:0]                           dbg_owner,
  output logic [$clog2(HOST_MAX_WAIT+1)-1:0]   dbg_host_wait
);

  localparam int WAIT_W = $clog2(HOST_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(HOST_MAX_WAIT);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IMEM, OWN_DMEM, OWN_HOST} owner_t;

  state_t            state;
  owner_t            owner;
  owner_t            win;
  logic [WAIT_W-1:0] host_wait;
  logic              host_promoted;
  logic              handshake;
  logic              host_grant;
  logic              resp_fire;

  assign host_promoted = (host_wait == WAIT_MAX);

  // Winner selection: a starved host jumps the queue, otherwise dmem > imem > host.
  always_comb begin
    win = OWN_NONE;
    if (host_req_valid && host_promoted) win = OWN_HOST;
    else if (dmem_req_valid)             win = OWN_DMEM;
    else if (imem_req_valid)             win = OWN_IMEM;
    else if (host_req_valid)             win = OWN_HOST;
  end

  always_comb begin
    mem_req_addr  = '0;
    mem_req_wen   = 1'b0;
    mem_req_wstrb = '0;
    mem_req_wdata = '0;
    case (win)
      OWN_IMEM: begin
        mem_req_addr  = imem_req_addr;
        mem_req_wen   = imem_req_wen;
        mem_req_wstrb = imem_req_wstrb;
        mem_req_wdata = imem_req_wdata;
      end
      OWN_DMEM: begin
        mem_req_addr  = dmem_req_addr;
        mem_req_wen   = dmem_req_wen;
        mem_req_wstrb = dmem_req_wstrb;
        mem_req_wdata = dmem_req_wdata;
      end
      OWN_HOST: begin
        mem_req_addr  = host_req_addr;
        mem_req_wen   = host_req_wen;
        mem_req_wstrb = host_req_wstrb;
        mem_req_wdata = host_req_wdata;
      end
      default: ;
    endcase
  end

  // Handshakes: a transfer happens on a cycle where valid & ready are both 1;
  // a requester holds valid and fields stable until it sees its ready.
  assign mem_req_valid  = !rst && (state == IDLE) && (win != OWN_NONE);
  assign handshake      = mem_req_valid && mem_req_ready;
  assign host_grant     = handshake && (win == OWN_HOST);

  assign imem_req_ready = handshake && (win == OWN_IMEM);
  assign dmem_req_ready = handshake && (win == OWN_DMEM);
  assign host_req_ready = handshake && (win == OWN_HOST);

  assign resp_fire       = !rst && (state == BUSY) && mem_resp_valid;
  assign imem_resp_valid = resp_fire && (owner == OWN_IMEM);
  assign dmem_resp_valid = resp_fire && (owner == OWN_DMEM);
  assign host_resp_valid = resp_fire && (owner == OWN_HOST);
  assign imem_resp_rdata = imem_resp_valid ? mem_resp_rdata : '0;
  assign dmem_resp_rdata = dmem_resp_valid ? mem_resp_rdata : '0;
  assign host_resp_rdata = host_resp_valid ? mem_resp_rdata : '0;

  assign busy          = !rst && (state == BUSY);
  assign dbg_state     = state;
  assign dbg_owner     = owner;
  assign dbg_host_wait = host_wait;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      owner         <= OWN_NONE;
      host_wait     <= '0;
      spurious_resp <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (handshake) begin
          state <= BUSY;
          owner <= win;
        end
        if (mem_resp_valid) spurious_resp <= 1'b1;
      end else if (mem_resp_valid) begin
        state <= IDLE;
        owner <= OWN_NONE;
      end
      // Host wait counts every cycle host is left waiting, including BUSY cycles.
      if (!host_req_valid || host_grant) host_wait <= '0;
      else if (host_wait != WAIT_MAX)    host_wait <= host_wait + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, all
// checked every cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int HOST_MAX_WAIT = 8;
  localparam int WAIT_W = 4;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int          who;
    int          cyc;
    logic [31:0] addr;
    logic        wen;
    logic [3:0]  wstrb;
    logic [31:0] data;
  } ev_t;

  typedef struct {
    int          who;
    logic [31:0] data;
  } txn_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              imem_req_valid = 0, dmem_req_valid = 0, host_req_valid = 0;
  logic [31:0]       imem_req_addr = 0, dmem_req_addr = 0, host_req_addr = 0;
  logic              imem_req_wen = 0, dmem_req_wen = 0, host_req_wen = 0;
  logic [3:0]        imem_req_wstrb = 0, dmem_req_wstrb = 0, host_req_wstrb = 0;
  logic [31:0]       imem_req_wdata = 0, dmem_req_wdata = 0, host_req_wdata = 0;
  logic              imem_req_ready, dmem_req_ready, host_req_ready;
  logic              imem_resp_valid, dmem_resp_valid, host_resp_valid;
  logic [31:0]       imem_resp_rdata, dmem_resp_rdata, host_resp_rdata;
  logic              mem_req_valid, mem_req_wen;
  logic              mem_req_ready = 0;
  logic [31:0]       mem_req_addr, mem_req_wdata;
  logic [3:0]        mem_req_wstrb;
  logic              mem_resp_valid = 0;
  logic [31:0]       mem_resp_rdata = 0;
  logic              busy, spurious_resp, dbg_state;
  logic [1:0]        dbg_owner;
  logic [WAIT_W-1:0] dbg_host_wait;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOST_MAX_WAIT(HOST_MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_req_wen(imem_req_wen), .imem_req_wstrb(imem_req_wstrb), .imem_req_wdata(imem_req_wdata),
    .imem_resp_valid(imem_resp_valid), .imem_resp_rdata(imem_resp_rdata),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_req_addr(dmem_req_addr),
    .dmem_req_wen(dmem_req_wen), .dmem_req_wstrb(dmem_req_wstrb), .dmem_req_wdata(dmem_req_wdata),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata),
    .host_req_valid(host_req_valid), .host_req_ready(host_req_ready), .host_req_addr(host_req_addr),
    .host_req_wen(host_req_wen), .host_req_wstrb(host_req_wstrb), .host_req_wdata(host_req_wdata),
    .host_resp_valid(host_resp_valid), .host_resp_rdata(host_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wstrb(mem_req_wstrb), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .busy(busy), .spurious_resp(spurious_resp),
    .dbg_state(dbg_state), .dbg_owner(dbg_owner), .dbg_host_wait(dbg_host_wait)
  );

  // ---------------- bench state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int busy_cycles = 0;

  req_t q_imem[$], q_dmem[$], q_host[$];
  ev_t  grant_log[$], resp_log[$];

  int          ready_pct = 100;
  int          lat_cfg   = 1;       // 0 selects a random latency of 1..3
  bit          pend      = 0;
  int          pend_cyc  = 0;
  logic [31:0] pend_data = 0;
  bit          inject    = 0;
  logic        s_rdy_i = 0, s_rdy_d = 0, s_rdy_h = 0;
  logic [31:0] env_mem[256];

  // reference model
  logic [31:0] gold[256];
  txn_t        m_out[$];
  int          m_wait = 0;
  bit          m_spur = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic req_t cur_req(input int who);
    req_t r;
    case (who)
      0:       r = '{addr: imem_req_addr, wen: imem_req_wen, wstrb: imem_req_wstrb, wdata: imem_req_wdata};
      1:       r = '{addr: dmem_req_addr, wen: dmem_req_wen, wstrb: dmem_req_wstrb, wdata: dmem_req_wdata};
      default: r = '{addr: host_req_addr, wen: host_req_wen, wstrb: host_req_wstrb, wdata: host_req_wdata};
    endcase
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push(input int who, input logic [31:0] addr, input logic wen,
                      input logic [3:0] wstrb, input logic [31:0] wdata);
    req_t r;
    r = '{addr: addr, wen: wen, wstrb: wstrb, wdata: wdata};
    case (who)
      0:       q_imem.push_back(r);
      1:       q_dmem.push_back(r);
      default: q_host.push_back(r);
    endcase
  endtask

  task automatic set_rst(input logic v);
    @(posedge clk);
    #1;
    rst = v;
  endtask

  task automatic clear_logs();
    grant_log.delete();
    resp_log.delete();
    busy_cycles = 0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((q_imem.size() != 0 || q_dmem.size() != 0 || q_host.size() != 0 ||
            pend || m_out.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, n >= budget, 1'b0);
    @(negedge clk);
  endtask

  // Requesters and memory: everything changes 1 time unit after the clock edge.
  initial forever begin : driver
    req_t r;
    req_t zr;
    @(posedge clk);
    #1;
    cyc++;
    zr = '{addr: 32'h0, wen: 1'b0, wstrb: 4'h0, wdata: 32'h0};
    if (s_rdy_i && q_imem.size() != 0) void'(q_imem.pop_front());
    if (s_rdy_d && q_dmem.size() != 0) void'(q_dmem.pop_front());
    if (s_rdy_h && q_host.size() != 0) void'(q_host.pop_front());
    imem_req_valid = (q_imem.size() != 0);
    r = imem_req_valid ? q_imem[0] : zr;
    imem_req_addr = r.addr; imem_req_wen = r.wen; imem_req_wstrb = r.wstrb; imem_req_wdata = r.wdata;
    dmem_req_valid = (q_dmem.size() != 0);
    r = dmem_req_valid ? q_dmem[0] : zr;
    dmem_req_addr = r.addr; dmem_req_wen = r.wen; dmem_req_wstrb = r.wstrb; dmem_req_wdata = r.wdata;
    host_req_valid = (q_host.size() != 0);
    r = host_req_valid ? q_host[0] : zr;
    host_req_addr = r.addr; host_req_wen = r.wen; host_req_wstrb = r.wstrb; host_req_wdata = r.wdata;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = 32'h0;
    if (pend && cyc == pend_cyc) begin
      mem_resp_valid = 1'b1;
      mem_resp_rdata = pend_data;
      pend = 0;
    end
    if (inject) begin
      mem_resp_valid = 1'b1;
      mem_resp_rdata = 32'h0BAD_0BAD;
      inject = 0;
    end
    mem_req_ready = (int'($urandom_range(0, 99)) < ready_pct);
  end

  // Memory side of the environment plus event logs, sampled mid-cycle.
  initial forever begin : env_sample
    int idx;
    @(negedge clk);
    s_rdy_i = imem_req_ready;
    s_rdy_d = dmem_req_ready;
    s_rdy_h = host_req_ready;
    if (mem_req_valid && mem_req_ready) begin
      grant_log.push_back('{who: imem_req_ready ? 0 : dmem_req_ready ? 1 : host_req_ready ? 2 : -1,
                            cyc: cyc, addr: mem_req_addr, wen: mem_req_wen,
                            wstrb: mem_req_wstrb, data: mem_req_wdata});
      idx = int'(mem_req_addr[9:2]);
      if (mem_req_wen) begin
        env_mem[idx] = merge(env_mem[idx], mem_req_wdata, mem_req_wstrb);
        pend_data = 32'h0;
      end else begin
        pend_data = env_mem[idx];
      end
      pend = 1;
      pend_cyc = cyc + ((lat_cfg == 0) ? int'($urandom_range(1, 3)) : lat_cfg);
    end
    if (imem_resp_valid) resp_log.push_back('{who: 0, cyc: cyc, addr: 0, wen: 0, wstrb: 0, data: imem_resp_rdata});
    if (dmem_resp_valid) resp_log.push_back('{who: 1, cyc: cyc, addr: 0, wen: 0, wstrb: 0, data: dmem_resp_rdata});
    if (host_resp_valid) resp_log.push_back('{who: 2, cyc: cyc, addr: 0, wen: 0, wstrb: 0, data: host_resp_rdata});
    if (busy) busy_cycles++;
  end

  // ---------------- scoreboard / reference model ----------------
  task automatic model_step();
    int          win;
    bit          idle;
    bit          resp_now;
    int          rwho;
    logic [31:0] rdat;
    req_t        w;
    int          idx;
    idle = (m_out.size() == 0);
    win  = -1;
    if (!rst && idle) begin
      if (host_req_valid && m_wait >= HOST_MAX_WAIT) win = 2;
      else if (dmem_req_valid)                      win = 1;
      else if (imem_req_valid)                      win = 0;
      else if (host_req_valid)                      win = 2;
    end
    w = cur_req((win < 0) ? 0 : win);
    chk("mem_req_valid", mem_req_valid, win >= 0);
    if (win >= 0) begin
      chk("mem_req_addr", mem_req_addr, w.addr);
      chk("mem_req_wen", mem_req_wen, w.wen);
      chk("mem_req_wstrb", mem_req_wstrb, w.wstrb);
      chk("mem_req_wdata", mem_req_wdata, w.wdata);
    end else if (!rst && idle) begin
      chk("mem_req_fields_idle", {mem_req_addr, mem_req_wdata}, 64'h0);
    end
    chk("imem_req_ready", imem_req_ready, win == 0 && mem_req_ready);
    chk("dmem_req_ready", dmem_req_ready, win == 1 && mem_req_ready);
    chk("host_req_ready", host_req_ready, win == 2 && mem_req_ready);
    resp_now = !rst && !idle && mem_resp_valid;
    rwho = resp_now ? m_out[0].who : -1;
    rdat = resp_now ? m_out[0].data : 32'h0;
    chk("imem_resp_valid", imem_resp_valid, rwho == 0);
    chk("dmem_resp_valid", dmem_resp_valid, rwho == 1);
    chk("host_resp_valid", host_resp_valid, rwho == 2);
    chk("imem_resp_rdata", imem_resp_rdata, (rwho == 0) ? rdat : 32'h0);
    chk("dmem_resp_rdata", dmem_resp_rdata, (rwho == 1) ? rdat : 32'h0);
    chk("host_resp_rdata", host_resp_rdata, (rwho == 2) ? rdat : 32'h0);
    chk("busy", busy, !rst && !idle);
    chk("spurious_resp", spurious_resp, m_spur);
    chk("host_wait", dbg_host_wait, m_wait);
    if (rst) begin
      m_out.delete();
      m_wait = 0;
      m_spur = 0;
    end else begin
      if (win >= 0 && mem_req_ready) begin
        idx = int'(w.addr[9:2]);
        if (w.wen) begin
          gold[idx] = merge(gold[idx], w.wdata, w.wstrb);
          m_out.push_back('{who: win, data: 32'h0});
        end else begin
          m_out.push_back('{who: win, data: gold[idx]});
        end
      end
      if (idle && mem_resp_valid)       m_spur = 1;
      else if (!idle && mem_resp_valid) void'(m_out.pop_front());
      if (!host_req_valid || (win == 2 && mem_req_ready)) m_wait = 0;
      else if (m_wait < HOST_MAX_WAIT)                    m_wait++;
    end
  endtask

  initial forever begin : compare
    @(negedge clk);
    model_step();
  end

  // ---------------- test sequence ----------------
  initial begin : main
    int c0;
    int n;
    for (int i = 0; i < 256; i++) gold[i] = 32'h3C00_0000 + i * 32'h0001_0103;
    gold[16]  = 32'h1111_0000;
    gold[17]  = 32'h2222_0000;
    gold[64]  = 32'h0000_0013;
    gold[128] = 32'hAAAA_AAAA;
    for (int i = 0; i < 256; i++) env_mem[i] = gold[i];
    repeat (3) @(posedge clk);
    set_rst(1'b0);

    // imem load, latency 2
    @(negedge clk);
    clear_logs();
    ready_pct = 100; lat_cfg = 2;
    push(0, 32'h0000_0100, 1'b0, 4'h0, 32'h0);
    wait_drain("t1_drain", 40);
    chk("t1_grants", grant_log.size(), 1);
    chk("t1_grant_who", grant_log[0].who, 0);
    chk("t1_resps", resp_log.size(), 1);
    chk("t1_resp_who", resp_log[0].who, 0);
    chk("t1_resp_data", resp_log[0].data, 32'h0000_0013);
    chk("t1_latency", resp_log[0].cyc - grant_log[0].cyc, 2);
    chk("t1_busy_cycles", busy_cycles, 2);

    // imem and dmem together: dmem first, imem right after the bubble
    @(negedge clk);
    clear_logs();
    lat_cfg = 1;
    push(1, 32'h0000_0040, 1'b0, 4'h0, 32'h0);
    push(0, 32'h0000_0044, 1'b0, 4'h0, 32'h0);
    wait_drain("t2_drain", 40);
    chk("t2_first_who", grant_log[0].who, 1);
    chk("t2_second_who", grant_log[1].who, 0);
    chk("t2_gap", grant_log[1].cyc - grant_log[0].cyc, 2);
    chk("t2_resp0", {resp_log[0].who, resp_log[0].data}, {32'd1, 32'h1111_0000});
    chk("t2_resp1", {resp_log[1].who, resp_log[1].data}, {32'd0, 32'h2222_0000});

    // dmem partial store then load-back
    @(negedge clk);
    clear_logs();
    push(1, 32'h0000_0200, 1'b1, 4'b0011, 32'hDEAD_BEEF);
    push(1, 32'h0000_0200, 1'b0, 4'h0, 32'h0);
    wait_drain("t3_drain", 40);
    chk("t3_addr", grant_log[0].addr, 32'h0000_0200);
    chk("t3_wen", grant_log[0].wen, 1'b1);
    chk("t3_wstrb", grant_log[0].wstrb, 4'b0011);
    chk("t3_wdata", grant_log[0].data, 32'hDEAD_BEEF);
    chk("t3_store_resp", {resp_log[0].who, resp_log[0].data}, {32'd1, 32'h0});
    chk("t3_load_back", resp_log[1].data, 32'hAAAA_BEEF);

    // host starvation against continuous dmem traffic
    @(negedge clk);
    clear_logs();
    push(2, 32'h0000_0010, 1'b0, 4'h0, 32'h0);
    for (int i = 0; i < 10; i++) push(1, 32'h0000_0020, 1'b0, 4'h0, 32'h0);
    wait_drain("t4_drain", 80);
    chk("t4_dmem_before", grant_log[3].who, 1);
    chk("t4_host_who", grant_log[4].who, 2);
    chk("t4_host_wait", grant_log[4].cyc - grant_log[0].cyc, 8);

    // memory not ready for 5 cycles
    @(negedge clk);
    clear_logs();
    ready_pct = 0;
    push(1, 32'h0000_0030, 1'b0, 4'h0, 32'h0);
    repeat (5) @(negedge clk);
    chk("t5_no_grant", grant_log.size(), 0);
    chk("t5_not_busy", busy, 1'b0);
    c0 = cyc;
    ready_pct = 100;
    wait_drain("t5_drain", 40);
    chk("t5_grant_cycle", grant_log[0].cyc, c0 + 1);

    // reset while BUSY, then a late response
    @(negedge clk);
    clear_logs();
    lat_cfg = 20;
    push(0, 32'h0000_0050, 1'b0, 4'h0, 32'h0);
    n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reached_busy", busy, 1'b1);
    set_rst(1'b1);
    pend = 0;
    repeat (2) @(posedge clk);
    set_rst(1'b0);
    @(negedge clk);
    inject = 1;
    repeat (3) @(negedge clk);
    chk("t6_no_resp", resp_log.size(), 0);
    chk("t6_spurious", spurious_resp, 1'b1);

    // random traffic
    ready_pct = 70; lat_cfg = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (q_imem.size() < 2 && $urandom_range(0, 99) < 30)
        push(0, 32'($urandom_range(0, 15)) << 2, 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
      if (q_dmem.size() < 2 && $urandom_range(0, 99) < 40)
        push(1, 32'($urandom_range(0, 15)) << 2, 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
      if (q_host.size() < 2 && $urandom_range(0, 99) < 25)
        push(2, 32'($urandom_range(0, 15)) << 2, 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
    end
    wait_drain("rand_drain", 500);
    chk("spurious_sticky", spurious_resp, 1'b1);

    set_rst(1'b1);
    set_rst(1'b0);
    @(negedge clk);
    chk("spurious_cleared", spurious_resp, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
